// File: rtl/cusp_filter_param_if.sv
// Sample/result bundle for the cusp shaping filter.
// master = sample source and result sink, slave = filter.
interface cusp_filter_param_if #(
  parameter int ADC_W = 12,
  parameter int OUT_W = 16
);
  logic             input_valid;
  logic [ADC_W-1:0] input_data;
  logic             output_valid;
  logic [OUT_W-1:0] output_data;
  logic             overflow;
  logic             primed;

  modport master (
    output input_valid,
    output input_data,
    input  output_valid,
    input  output_data,
    input  overflow,
    input  primed
  );

  modport slave (
    input  input_valid,
    input  input_data,
    output output_valid,
    output output_data,
    output overflow,
    output primed
  );
endinterface

// File: rtl/cusp_filter_param.sv
// Parametrised cusp-like shaping filter, one ADC channel.
// 4-clock pipeline: t -> p -> q/s -> saturated y.
module cusp_filter_param #(
  parameter int ADC_W = 12,
  parameter int OUT_W = 16,
  parameter int ACC_W = 40,
  parameter int L     = 5,
  parameter int K     = 11,
  parameter int M1    = 16,
  parameter int M2    = 1,
  parameter int SHIFT = 4
) (
  input logic clk,
  input logic reset,
  input logic clear,
  cusp_filter_param_if.slave bus
);

  if (L < 1 || L >= K || K > 64 || ACC_W <= OUT_W) begin : g_bad_param
    $error("cusp_filter_param: illegal L/K/ACC_W");
  end

  localparam int D = (K > L + 1) ? K : L + 1;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic {EMPTY, RUN} state_t;

  localparam acc_t K_A  = acc_t'(K);
  localparam acc_t M1_A = acc_t'(M1);
  localparam acc_t M2_A = acc_t'(M2);

  state_t state, state_nx;

  logic [ADC_W-1:0] taps [D];
  acc_t t_r, p_r, q_r, s_r;
  acc_t t_nx, q_nx, sh;
  logic [2:0] vld;
  logic kill, accept;
  logic pos_ovf, neg_ovf;
  logic [OUT_W-1:0] y_nx;
  logic [OUT_W-1:0] out_r;
  logic out_vld_r;
  logic ovf_r;

  function automatic acc_t zx(input logic [ADC_W-1:0] x);
    zx = acc_t'({{(ACC_W-ADC_W){1'b0}}, x});
  endfunction

  assign kill   = reset | clear;
  assign accept = bus.input_valid & ~kill;

  // next state: the first accepted sample primes the filter
  always_comb begin
    state_nx = state;
    if (accept) state_nx = RUN;
  end

  // state register
  always_ff @(posedge clk) begin
    if (kill) state <= EMPTY;
    else      state <= state_nx;
  end

  // delay line: baseline fills every tap, later samples shift in
  always_ff @(posedge clk) begin
    if (kill) begin
      for (int i = 0; i < D; i++) taps[i] <= '0;
    end else if (accept) begin
      if (state == EMPTY) begin
        for (int i = 0; i < D; i++) taps[i] <= bus.input_data;
      end else begin
        taps[0] <= bus.input_data;
        for (int i = 1; i < D; i++) taps[i] <= taps[i-1];
      end
    end
  end

  // taps[i] holds v(n-1-i); baseline sample sees all taps equal -> t=0
  always_comb begin
    t_nx = '0;
    if (state == RUN) begin
      t_nx = zx(bus.input_data) - zx(taps[K-1])
           - K_A * (zx(taps[L-1]) - zx(taps[L]));
    end
  end

  // second integrator and floor shift with clamp to OUT_W
  always_comb begin
    q_nx    = q_r + M2_A * p_r;
    sh      = s_r >>> SHIFT;
    pos_ovf = ~sh[ACC_W-1] & (|sh[ACC_W-2:OUT_W-1]);
    neg_ovf = sh[ACC_W-1] & ~(&sh[ACC_W-2:OUT_W-1]);
    y_nx    = sh[OUT_W-1:0];
    if (pos_ovf)      y_nx = {1'b0, {(OUT_W-1){1'b1}}};
    else if (neg_ovf) y_nx = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // datapath pipeline; accumulators move only for valid slots
  always_ff @(posedge clk) begin
    if (kill) begin
      t_r       <= '0;
      p_r       <= '0;
      q_r       <= '0;
      s_r       <= '0;
      vld       <= '0;
      out_r     <= '0;
      out_vld_r <= 1'b0;
    end else begin
      vld       <= {vld[1:0], accept};
      out_vld_r <= vld[2];
      if (accept) t_r <= t_nx;
      if (vld[0]) p_r <= p_r + t_r;
      if (vld[1]) begin
        q_r <= q_nx;
        s_r <= s_r + q_nx + M1_A * p_r;
      end
      if (vld[2]) out_r <= y_nx;
    end
  end

  // sticky saturation flag survives clear
  always_ff @(posedge clk) begin
    if (reset)
      ovf_r <= 1'b0;
    else if (!clear && vld[2] && (pos_ovf || neg_ovf))
      ovf_r <= 1'b1;
  end

  assign bus.output_valid = out_vld_r;
  assign bus.output_data  = out_r;
  assign bus.overflow     = ovf_r;
  assign bus.primed       = (state == RUN);

endmodule

// File: tb/tb_cusp_filter_param.sv
// Directed bench for cusp_filter_param.
// Hand-computed step responses plus clear/reset sequences.
module tb_cusp_filter_param;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  always #5 clk = ~clk;

  cusp_filter_param_if #(.ADC_W(12), .OUT_W(16)) bus ();

  cusp_filter_param dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] din;
    int          ey;
  } vec_t;

  vec_t tab [23];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int oq_y [$];
  int oq_c [$];
  int in_c [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [11:0] d, input logic c);
    bus.input_valid = v;
    bus.input_data  = d;
    clear = c;
    @(posedge clk);
    #1;
    cyc++;
    if (v && !c && !reset) in_c.push_back(cyc);
    if (bus.output_valid) begin
      oq_y.push_back(int'($signed(bus.output_data)));
      oq_c.push_back(cyc);
    end
  endtask

  task automatic flush();
    oq_y.delete();
    oq_c.delete();
    in_c.delete();
  endtask

  task automatic drain();
    repeat (6) tick(1'b0, 12'd0, 1'b0);
  endtask

  task automatic run_tab(input string name, input int st, input int n,
                         input bit gap);
    flush();
    for (int i = 0; i < n; i++) begin
      tick(1'b1, tab[st+i].din, 1'b0);
      if (gap) tick(1'b0, 12'd0, 1'b0);
    end
    drain();
    check({name, "_count"}, oq_y.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < oq_y.size() && i < in_c.size()) begin
        check($sformatf("%s_y%0d", name, i), oq_y[i], tab[st+i].ey);
        check($sformatf("%s_lat%0d", name, i), oq_c[i] - in_c[i], 3);
      end
    end
  endtask

  initial begin
    int nz;
    int last_y;

    tab[0]  = '{12'd0,  0};
    tab[1]  = '{12'd16, 17};
    tab[2]  = '{12'd16, 52};
    tab[3]  = '{12'd16, 106};
    tab[4]  = '{12'd16, 180};
    tab[5]  = '{12'd16, 275};
    tab[6]  = '{12'd16, 205};
    tab[7]  = '{12'd16, 147};
    tab[8]  = '{12'd16, 102};
    tab[9]  = '{12'd16, 71};
    tab[10] = '{12'd16, 55};
    tab[11] = '{12'd16, 55};
    tab[12] = '{12'd16, 55};
    tab[13] = '{12'd0,    0};
    tab[14] = '{12'd4095, 4350};
    tab[15] = '{12'd4095, 13308};
    tab[16] = '{12'd4095, 27129};
    tab[17] = '{12'd4095, 32767};
    tab[18] = '{12'd4095, 32767};
    tab[19] = '{12'd4095, 32767};
    tab[20] = '{12'd4095, 32767};
    tab[21] = '{12'd4095, 26105};
    tab[22] = '{12'd4095, 18171};

    reset = 1'b1;
    clear = 1'b0;
    bus.input_valid = 1'b0;
    bus.input_data  = '0;
    repeat (2) tick(1'b0, 12'd0, 1'b0);
    check("rst_valid", int'(bus.output_valid), 0);
    check("rst_data", int'(bus.output_data), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_primed", int'(bus.primed), 0);
    reset = 1'b0;
    tick(1'b0, 12'd0, 1'b0);

    // constant input gives zero output
    flush();
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 12'd500, 1'b0);
      if (i == 0) check("t1_primed", int'(bus.primed), 1);
    end
    drain();
    check("t1_count", oq_y.size(), 100);
    nz = 0;
    foreach (oq_y[i]) if (oq_y[i] != 0) nz++;
    check("t1_nonzero", nz, 0);
    if (oq_c.size() > 0 && in_c.size() > 0)
      check("t1_first_lat", oq_c[0] - in_c[0], 3);
    tick(1'b0, 12'd0, 1'b1);
    check("t1_clr_primed", int'(bus.primed), 0);

    // step response, back-to-back and with gaps
    run_tab("t2", 0, 13, 1'b0);
    tick(1'b0, 12'd0, 1'b1);
    run_tab("t3", 0, 13, 1'b1);
    tick(1'b0, 12'd0, 1'b1);
    check("t3_ovf", int'(bus.overflow), 0);

    // clear together with the 3rd step sample
    flush();
    tick(1'b1, 12'd0, 1'b0);
    tick(1'b1, 12'd16, 1'b0);
    tick(1'b1, 12'd16, 1'b0);
    tick(1'b1, 12'd16, 1'b1);
    check("t5_primed", int'(bus.primed), 0);
    check("t5_valid", int'(bus.output_valid), 0);
    check("t5_early", oq_y.size(), 0);
    repeat (5) tick(1'b1, 12'd16, 1'b0);
    drain();
    check("t5_count", oq_y.size(), 5);
    nz = 0;
    foreach (oq_y[i]) if (oq_y[i] != 0) nz++;
    check("t5_nonzero", nz, 0);
    tick(1'b0, 12'd0, 1'b1);

    // reset mid-step, then restart from EMPTY
    flush();
    tick(1'b1, 12'd0, 1'b0);
    repeat (6) tick(1'b1, 12'd16, 1'b0);
    last_y = int'($signed(bus.output_data));
    check("t6_pre_y", last_y, 106);
    reset = 1'b1;
    tick(1'b1, 12'd16, 1'b0);
    reset = 1'b0;
    check("t6_valid", int'(bus.output_valid), 0);
    check("t6_data", int'(bus.output_data), 0);
    check("t6_primed", int'(bus.primed), 0);
    check("t6_ovf", int'(bus.overflow), 0);
    run_tab("t6", 0, 13, 1'b0);
    tick(1'b0, 12'd0, 1'b1);

    // full-scale step saturates; flag is sticky
    run_tab("t4", 13, 10, 1'b0);
    check("t4_ovf", int'(bus.overflow), 1);
    repeat (12) tick(1'b1, 12'd0, 1'b0);
    drain();
    check("t4_ovf_hold", int'(bus.overflow), 1);
    tick(1'b0, 12'd0, 1'b1);
    check("t4_ovf_clr", int'(bus.overflow), 1);
    check("t4_primed_clr", int'(bus.primed), 0);
    reset = 1'b1;
    tick(1'b0, 12'd0, 1'b0);
    reset = 1'b0;
    check("t4_ovf_rst", int'(bus.overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
